// File: rtl/gpio_irq_ctrl8_if.sv
// APB slave bus bundle for the GPIO interrupt controller.
// Latency: n/a (wires only). prdata is driven combinationally by the slave.
// Backpressure: none; the bus has zero wait states and no pready.
// Ports: psel/penable/pwrite/paddr/pwdata from master, prdata from slave.
interface gpio_irq_ctrl8_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata
  );
endinterface

// File: rtl/gpio_irq_ctrl8.sv
// GPIO controller: pad direction/data, synchronised inputs, edge capture into W1C status, maskable irq.
// Latency: IN valid SYNC_STAGES edges after a pin change; STATUS and gpio_irq one edge later.
// Backpressure: none; APB writes commit at the access-phase edge, reads are combinational.
// Ports: pclk8, n_p_reset8 (async, active-low), apb (slave modport), n_gpio_pin_oe8,
//        gpio_pin_out8, gpio_pin_in8 (asynchronous), gpio_irq (level, active-high).
module gpio_irq_ctrl8 #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk8,
  input  logic                  n_p_reset8,
  gpio_irq_ctrl8_if.slave       apb,
  output logic [DATA_WIDTH-1:0] n_gpio_pin_oe8,
  output logic [DATA_WIDTH-1:0] gpio_pin_out8,
  input  logic [DATA_WIDTH-1:0] gpio_pin_in8,
  output logic                  gpio_irq
);

  localparam logic [2:0] A_DIR    = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_RISE   = 3'd3;
  localparam logic [2:0] A_FALL   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_MASK   = 3'd6;

  logic [DATA_WIDTH-1:0] dir_q, out_q, rise_en_q, fall_en_q, status_q, mask_q;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] sync_val, edge_set, w1c, wdat;
  logic [2:0]            addr;
  logic                  wr_en;
  logic [31:0]           rd_word;

  assign addr     = apb.paddr[4:2];
  assign wdat     = apb.pwdata[DATA_WIDTH-1:0];
  assign wr_en    = apb.psel & apb.penable & apb.pwrite;
  assign sync_val = sync_q[SYNC_STAGES-1];

  // Edge qualifiers compare the synchronised value against last cycle's copy.
  assign edge_set = ((sync_val & ~prev_q) & rise_en_q) | ((~sync_val & prev_q) & fall_en_q);
  assign w1c      = (wr_en && addr == A_STATUS) ? wdat : '0;

  // Pin synchroniser and previous-value register.
  always_ff @(posedge pclk8 or negedge n_p_reset8) begin
    if (!n_p_reset8) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_pin_in8;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_val;
    end
  end

  // Control registers and status; a new edge beats a same-edge W1C.
  always_ff @(posedge pclk8 or negedge n_p_reset8) begin
    if (!n_p_reset8) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask_q    <= '0;
      status_q  <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          A_DIR:   dir_q     <= wdat;
          A_OUT:   out_q     <= wdat;
          A_RISE:  rise_en_q <= wdat;
          A_FALL:  fall_en_q <= wdat;
          A_MASK:  mask_q    <= wdat;
          default: ;
        endcase
      end
      status_q <= (status_q & ~w1c) | edge_set;
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      A_DIR:    rd_word[DATA_WIDTH-1:0] = dir_q;
      A_OUT:    rd_word[DATA_WIDTH-1:0] = out_q;
      A_IN:     rd_word[DATA_WIDTH-1:0] = sync_val;
      A_RISE:   rd_word[DATA_WIDTH-1:0] = rise_en_q;
      A_FALL:   rd_word[DATA_WIDTH-1:0] = fall_en_q;
      A_STATUS: rd_word[DATA_WIDTH-1:0] = status_q;
      A_MASK:   rd_word[DATA_WIDTH-1:0] = mask_q;
      default:  rd_word = '0;
    endcase
  end

  assign apb.prdata     = (apb.psel && !apb.pwrite) ? rd_word : 32'd0;
  assign n_gpio_pin_oe8 = ~dir_q;
  assign gpio_pin_out8  = out_q;
  assign gpio_irq       = |(status_q & mask_q);

  // Byte-lane address bits and write data above the pin count carry no meaning here.
  generate
    if (DATA_WIDTH < 32) begin : g_unused_hi
      logic unused_bits;
      assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[31:DATA_WIDTH]};
    end else begin : g_unused_lo
      logic unused_bits;
      assign unused_bits = ^apb.paddr[1:0];
    end
  endgenerate

endmodule

// File: tb/tb_gpio_irq_ctrl8.sv
// Testbench for gpio_irq_ctrl8: directed steps followed by random traffic against a register-level model.
// Latency: model tracks pin history as a delay line of sampled pin values.
// Backpressure: none; bench drives APB with two-cycle writes and combinational reads.
module tb_gpio_irq_ctrl8;
  localparam int DW = 16;
  localparam int SS = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] pins;
  logic [DW-1:0] n_oe, pout;
  logic          irq;

  gpio_irq_ctrl8_if bus ();

  gpio_irq_ctrl8 #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .pclk8          (clk),
    .n_p_reset8     (rst_n),
    .apb            (bus),
    .n_gpio_pin_oe8 (n_oe),
    .gpio_pin_out8  (pout),
    .gpio_pin_in8   (pins),
    .gpio_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: register contents plus the history of pin values seen at each edge.
  logic [DW-1:0] m_dir, m_out, m_rise, m_fall, m_st, m_mask;
  logic [DW-1:0] hist [0:SS];

  task automatic model_reset();
    m_dir = '0; m_out = '0; m_rise = '0; m_fall = '0; m_st = '0; m_mask = '0;
    for (int i = 0; i <= SS; i++) hist[i] = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'd0, m_dir};
      3'd1: return {16'd0, m_out};
      3'd2: return {16'd0, hist[SS-1]};
      3'd3: return {16'd0, m_rise};
      3'd4: return {16'd0, m_fall};
      3'd5: return {16'd0, m_st};
      3'd6: return {16'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model using the bus and pins as they stand, then compare outputs.
  task automatic tick();
    logic [DW-1:0] s, p, set, w;
    s   = hist[SS-1];
    p   = hist[SS];
    set = (s & ~p & m_rise) | (~s & p & m_fall);
    w   = '0;
    if (bus.psel && bus.penable && bus.pwrite) begin
      case (bus.paddr[4:2])
        3'd0: m_dir  = bus.pwdata[DW-1:0];
        3'd1: m_out  = bus.pwdata[DW-1:0];
        3'd3: m_rise = bus.pwdata[DW-1:0];
        3'd4: m_fall = bus.pwdata[DW-1:0];
        3'd5: w      = bus.pwdata[DW-1:0];
        3'd6: m_mask = bus.pwdata[DW-1:0];
        default: ;
      endcase
    end
    m_st = (m_st & ~w) | set;
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pins;
    @(posedge clk);
    #1;
    chk("oe", {16'd0, n_oe}, {16'd0, ~m_dir});
    chk("out", {16'd0, pout}, {16'd0, m_out});
    chk("irq", {31'd0, irq}, {31'd0, |(m_st & m_mask)});
    chk("prdata_idle", bus.prdata, 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = {a, 2'b00}; bus.pwdata = d;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = {a, 2'b00};
    #1;
    chk(tag, bus.prdata, exp);
    bus.psel = 1'b0;
  endtask

  initial begin
    logic [2:0]  ra;
    logic [31:0] rd;
    rst_n = 1'b0;
    pins = '0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    model_reset();

    // Reset state.
    #22;
    chk("rst_oe", {16'd0, n_oe}, 32'h0000_FFFF);
    chk("rst_out", {16'd0, pout}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_prdata", bus.prdata, 32'd0);
    #5 rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) peek("rst_read", 3'(a), 32'd0);

    // Direction and output data.
    apb_write(3'd0, 32'h0000_00F0);
    apb_write(3'd1, 32'hFFFF_00A5);
    chk("dir_oe", {16'd0, n_oe}, 32'h0000_FF0F);
    chk("dir_out", {16'd0, pout}, 32'h0000_00A5);
    peek("rd_dir", 3'd0, 32'h0000_00F0);
    peek("rd_out", 3'd1, 32'h0000_00A5);
    peek("rd_rsvd", 3'd7, 32'd0);

    // Rising edge on pin 0, latency and W1C clear.
    apb_write(3'd3, 32'h1);
    apb_write(3'd6, 32'h1);
    pins[0] = 1'b1;
    tick();
    peek("in_e1", 3'd2, 32'h0);
    tick();
    peek("in_e2", 3'd2, 32'h1);
    peek("st_e2", 3'd5, 32'h0);
    chk("irq_e2", {31'd0, irq}, 32'd0);
    tick();
    peek("st_e3", 3'd5, 32'h1);
    chk("irq_e3", {31'd0, irq}, 32'd1);
    apb_write(3'd5, 32'h1);
    peek("st_w1c", 3'd5, 32'h0);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // Falling edge on pin 1 while masked, then unmask.
    apb_write(3'd4, 32'h2);
    apb_write(3'd3, 32'h3);
    apb_write(3'd6, 32'h0);
    pins[1] = 1'b1;
    ticks(4);
    apb_write(3'd5, 32'hFFFF_FFFF);
    pins[1] = 1'b0;
    ticks(3);
    peek("st_fall", 3'd5, 32'h2);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    apb_write(3'd6, 32'h2);
    chk("irq_unmask", {31'd0, irq}, 32'd1);
    apb_write(3'd5, 32'hFFFF);

    // W1C on the same edge as a new rising edge: set wins.
    apb_write(3'd4, 32'h3);
    pins[0] = 1'b0;
    ticks(3);
    peek("st_pre", 3'd5, 32'h1);
    pins[0] = 1'b1;
    tick();
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = {3'd5, 2'b00}; bus.pwdata = 32'h1;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    peek("st_collide", 3'd5, 32'h1);
    apb_write(3'd5, 32'h1);
    peek("st_clear", 3'd5, 32'h0);

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: begin pins = DW'($urandom); tick(); end
        1: apb_write(3'($urandom_range(0, 7)), $urandom);
        2: begin
          ra = 3'($urandom_range(0, 7));
          rd = m_read(ra);
          peek("rand_read", ra, rd);
          tick();
        end
        default: tick();
      endcase
    end

    // Pending status lost on asynchronous reset.
    apb_write(3'd4, 32'h0);
    apb_write(3'd3, 32'h3);
    apb_write(3'd6, 32'h3);
    pins = '0;
    ticks(4);
    apb_write(3'd5, 32'hFFFF_FFFF);
    pins = 16'h0003;
    ticks(3);
    peek("st_pend", 3'd5, 32'h3);
    chk("irq_pend", {31'd0, irq}, 32'd1);
    #2;
    rst_n = 1'b0;
    pins = '0;
    #1;
    chk("arst_irq", {31'd0, irq}, 32'd0);
    chk("arst_oe", {16'd0, n_oe}, 32'h0000_FFFF);
    chk("arst_out", {16'd0, pout}, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int a = 0; a < 8; a++) peek("post_rst_read", 3'(a), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
